// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: management-side transmitter for the GPIO configuration shift chain.
// Keeps one PAD_CTRL_BITS word per control block and, on request, shifts the whole chain
// image out (farthest block first, MSB first), then pulses the load strobe.
// Optional feature: define GPIO_LOADER_BITBANG_EN to add direct bit-bang control of the
// serial pins while the FSM is idle.
module gpio_serial_loader #(
    parameter int unsigned NUM_GPIO      = 19,
    parameter int unsigned PAD_CTRL_BITS = 10,
    parameter int unsigned CLK_DIV       = 1,
    parameter logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULT = 10'h403,
    localparam int unsigned AW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     cfg_wr_en,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0] cfg_wdata,
    output logic [PAD_CTRL_BITS-1:0] cfg_rdata,
    input  logic                     xfer_start,
`ifdef GPIO_LOADER_BITBANG_EN
    input  logic                     bb_en,
    input  logic                     bb_clock,
    input  logic                     bb_load,
    input  logic                     bb_resetn,
    input  logic                     bb_data,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     serial_clock,
    output logic                     serial_load,
    output logic                     serial_resetn,
    output logic                     serial_data_out
);

    localparam int unsigned BW = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
    localparam int unsigned CW = $clog2(NUM_GPIO * PAD_CTRL_BITS + 1);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [AW:0]   NUM_WORDS  = (AW + 1)'(NUM_GPIO);
    localparam logic [AW-1:0] LAST_WORD  = AW'(NUM_GPIO - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(PAD_CTRL_BITS - 1);
    localparam logic [CW-1:0] TOTAL_BITS = CW'(NUM_GPIO * PAD_CTRL_BITS);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLoadHi,
        StLoadLo
    } state_e;

    state_e state_q, state_d;

    logic [PAD_CTRL_BITS-1:0] mem_q [NUM_GPIO];
    logic [DW-1:0]            div_q, div_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [AW-1:0]            word_q, word_d;
    logic [BW-1:0]            bit_q, bit_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic sclk_q, sclk_d;
    logic load_q, load_d;
    logic resetn_q, resetn_d;
    logic data_q, data_d;

    logic                     addr_ok;
    logic                     wr_fire;
    logic                     start;
    logic                     phase_end;
    logic [PAD_CTRL_BITS-1:0] sel_word;

    assign addr_ok   = ({1'b0, cfg_addr} < NUM_WORDS);
    assign wr_fire   = cfg_wr_en && !busy_q && addr_ok;
    assign cfg_rdata = addr_ok ? mem_q[cfg_addr] : '0;
    assign phase_end = (div_q == DIV_LAST);

`ifdef GPIO_LOADER_BITBANG_EN
    assign start = xfer_start && !bb_en;
`else
    assign start = xfer_start;
`endif

    // Configuration store; writes are locked out for the whole transfer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
                mem_q[i] <= GPIO_DEFAULT;
            end
        end else if (wr_fire) begin
            mem_q[cfg_addr] <= cfg_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: phase timer, bit/word pointers and the remaining-bit down-counter.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        bit_d   = bit_q;
        case (state_q)
            StIdle: begin
                div_d = '0;
                if (start) begin
                    state_d = StShiftLo;
                    cnt_d   = TOTAL_BITS;
                    word_d  = LAST_WORD;
                    bit_d   = LAST_BIT;
                end
            end
            StShiftLo: begin
                div_d = div_q + DW'(1);
                if (phase_end) begin
                    div_d   = '0;
                    state_d = StShiftHi;
                end
            end
            StShiftHi: begin
                div_d = div_q + DW'(1);
                if (phase_end) begin
                    div_d = '0;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = StLoadHi;
                    end else begin
                        // Advance on the falling edge so data is settled at the next rise.
                        state_d = StShiftLo;
                        if (bit_q == '0) begin
                            bit_d  = LAST_BIT;
                            word_d = word_q - AW'(1);
                        end else begin
                            bit_d = bit_q - BW'(1);
                        end
                    end
                end
            end
            StLoadHi: begin
                div_d = div_q + DW'(1);
                if (phase_end) begin
                    div_d   = '0;
                    state_d = StLoadLo;
                end
            end
            StLoadLo: begin
                div_d = div_q + DW'(1);
                if (phase_end) begin
                    div_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next-values are derived from the next state so every pin is a flop.
    always_comb begin
        // Forward a same-cycle write so a start coincident with a write uses the new word.
        sel_word = (wr_fire && (cfg_addr == word_d)) ? cfg_wdata : mem_q[word_d];
        busy_d   = (state_d != StIdle);
        done_d   = (state_q == StLoadLo) && (state_d == StIdle);
        sclk_d   = (state_d == StShiftHi);
        load_d   = (state_d == StLoadHi);
        resetn_d = 1'b1;
        data_d   = ((state_d == StShiftLo) || (state_d == StShiftHi)) ? sel_word[bit_d] : 1'b0;
`ifdef GPIO_LOADER_BITBANG_EN
        if (bb_en && (state_q == StIdle)) begin
            sclk_d   = bb_clock;
            load_d   = bb_load;
            resetn_d = bb_resetn;
            data_d   = bb_data;
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div_q    <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            load_q   <= 1'b0;
            resetn_q <= 1'b0;
            data_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            bit_q    <= bit_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            load_q   <= load_d;
            resetn_q <= resetn_d;
            data_q   <= data_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign serial_clock    = sclk_q;
    assign serial_load     = load_q;
    assign serial_resetn   = resetn_q;
    assign serial_data_out = data_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader with a two-block behavioural chain attached.
module tb_gpio_serial_loader;

    localparam int unsigned NG  = 2;
    localparam int unsigned PB  = 10;
    localparam int unsigned CD  = 2;
    localparam logic [9:0]  DEF = 10'h403;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       cfg_wr_en = 1'b0;
    logic [0:0] cfg_addr = '0;
    logic [9:0] cfg_wdata = '0;
    logic [9:0] cfg_rdata;
    logic       xfer_start = 1'b0;
    logic       busy, done, serial_clock, serial_load, serial_resetn, serial_data_out;
`ifdef GPIO_LOADER_BITBANG_EN
    logic bb_en = 1'b0, bb_clock = 1'b0, bb_load = 1'b0, bb_resetn = 1'b1, bb_data = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    gpio_serial_loader #(
        .NUM_GPIO     (NG),
        .PAD_CTRL_BITS(PB),
        .CLK_DIV      (CD),
        .GPIO_DEFAULT (DEF)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .xfer_start     (xfer_start),
`ifdef GPIO_LOADER_BITBANG_EN
        .bb_en          (bb_en),
        .bb_clock       (bb_clock),
        .bb_load        (bb_load),
        .bb_resetn      (bb_resetn),
        .bb_data        (bb_data),
`endif
        .busy           (busy),
        .done           (done),
        .serial_clock   (serial_clock),
        .serial_load    (serial_load),
        .serial_resetn  (serial_resetn),
        .serial_data_out(serial_data_out)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Activity monitors (monotonic; tests take differences).
    int rises = 0, busy_cyc = 0, done_cnt = 0, load_cyc = 0, load_pulses = 0;
    logic [19:0] bits = '0;
    always @(posedge serial_clock) begin
        rises++;
        bits = {bits[18:0], serial_data_out};
    end
    always @(posedge serial_load) load_pulses++;
    always @(posedge wb_clk_i) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (serial_load) load_cyc++;
    end

    // Two chained control blocks; block0 is nearest the loader.
    logic [9:0] sh0, sh1, ld0, ld1;
    always @(posedge serial_clock or negedge serial_resetn) begin
        if (!serial_resetn) begin
            sh0 <= '0;
            sh1 <= '0;
        end else begin
            sh0 <= {sh0[8:0], serial_data_out};
            sh1 <= {sh1[8:0], sh0[9]};
        end
    end
    always @(posedge serial_load or negedge serial_resetn) begin
        if (!serial_resetn) begin
            ld0 <= DEF;
            ld1 <= DEF;
        end else begin
            ld0 <= sh0;
            ld1 <= sh1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic write_word(input logic a, input logic [9:0] d);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_wr_en = 1'b1;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic a, input logic [9:0] e);
        cfg_addr = a;
        #1;
        check(tag, 32'(cfg_rdata), 32'(e));
    endtask

    task automatic pulse_start();
        xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    int r0, b0, d0, l0, lp0;
    task automatic snap();
        r0 = rises; b0 = busy_cyc; d0 = done_cnt; l0 = load_cyc; lp0 = load_pulses;
    endtask

    task automatic check_xfer(input string tag, input logic [9:0] w1, input logic [9:0] w0);
        logic [19:0] exp_bits;
        exp_bits = {w1, w0};
        check({tag, "_rises"}, 32'(rises - r0), 32'd20);
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_busy_cycles"}, 32'(busy_cyc - b0), 32'd84);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_load_pulses"}, 32'(load_pulses - lp0), 32'd1);
        check({tag, "_load_width"}, 32'(load_cyc - l0), 32'd2);
        check({tag, "_blk1"}, 32'(ld1), 32'(w1));
        check({tag, "_blk0"}, 32'(ld0), 32'(w0));
    endtask

    initial begin
        logic hit;
        // Reset state.
        repeat (3) tick();
        check("rst_resetn", 32'(serial_resetn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pins", 32'({serial_clock, serial_load, serial_data_out, done}), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        check("rel_resetn_low", 32'(serial_resetn), 32'd0);
        tick();
        check("rel_resetn_high", 32'(serial_resetn), 32'd1);
        read_check("rd_def0", 1'b0, DEF);
        read_check("rd_def1", 1'b1, DEF);

        // Basic transfer.
        write_word(1'b1, 10'h2A5);
        write_word(1'b0, 10'h0F3);
        read_check("rd_w1", 1'b1, 10'h2A5);
        read_check("rd_w0", 1'b0, 10'h0F3);
        check("idle_busy", 32'(busy), 32'd0);
        snap();
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_sclk", 32'(serial_clock), 32'd0);
        check("start_first_bit", 32'(serial_data_out), 32'd1);
        wait_done("x1", 200);
        tick();
        check("x1_done_one_cycle", 32'(done), 32'd0);
        check_xfer("x1", 10'h2A5, 10'h0F3);
        check("x1_bits_literal", 32'(bits), 32'(20'b1010100101_0011110011));
        check("idle_pins", 32'({serial_clock, serial_data_out, serial_load}), 32'd0);

        // Write and second start while busy are both dropped.
        snap();
        pulse_start();
        repeat (3) tick();
        cfg_addr = 1'b0; cfg_wdata = 10'h3FF; cfg_wr_en = 1'b1; xfer_start = 1'b1;
        tick();
        cfg_wr_en = 1'b0; xfer_start = 1'b0;
        read_check("busy_wr_dropped", 1'b0, 10'h0F3);
        wait_done("x2", 200);
        repeat (100) tick();
        check_xfer("x2", 10'h2A5, 10'h0F3);
        check("x2_idle_after", 32'(busy), 32'd0);

        // Reset at the 7th shift clock.
        snap();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rises - r0 == 7) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("mid_reached_7", 32'(hit), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check("mid_pins", 32'({serial_clock, serial_load, serial_data_out}), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_resetn", 32'(serial_resetn), 32'd0);
        check("mid_chain_default", 32'({ld1, ld0}), 32'({DEF, DEF}));
        read_check("mid_store_default", 1'b0, DEF);
        repeat (2) tick();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        tick();

        // Fresh transfer; word1 written in the same cycle as start.
        write_word(1'b0, 10'h2CA);
        snap();
        cfg_addr = 1'b1; cfg_wdata = 10'h155; cfg_wr_en = 1'b1; xfer_start = 1'b1;
        tick();
        cfg_wr_en = 1'b0; xfer_start = 1'b0;
        check("coinc_first_bit", 32'(serial_data_out), 32'd0);
        wait_done("x3", 200);
        tick();
        check_xfer("x3", 10'h155, 10'h2CA);

`ifdef GPIO_LOADER_BITBANG_EN
        bb_en = 1'b1; bb_clock = 1'b1; bb_data = 1'b1; bb_load = 1'b0; bb_resetn = 1'b1;
        #1;
        check("bb_latency", 32'(serial_clock), 32'd0);
        tick();
        check("bb_follow_hi", 32'({serial_clock, serial_data_out}), 32'd3);
        bb_clock = 1'b0; bb_data = 1'b0;
        tick();
        check("bb_follow_lo", 32'({serial_clock, serial_data_out}), 32'd0);
        pulse_start();
        tick();
        check("bb_start_ignored", 32'(busy), 32'd0);
        bb_en = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
